// File: rtl/mem_access_unit_if.sv
// Data-memory request/acknowledge bus between the MEM-stage access unit and data memory.
// The unit is the master; the memory (or its model) is the slave.
interface mem_access_unit_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mem_access_unit.sv
// MIPS MEM-stage data-memory access unit: issues loads/stores over a req/ack bus,
// stalls upstream while an access is outstanding and registers results for MEM/WB.
module mem_access_unit (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_in,
  input  logic                mem_read_in,
  input  logic                mem_write_in,
  input  logic [1:0]          size_in,
  input  logic                unsigned_in,
  input  logic [31:0]         alu_result_in,
  input  logic [31:0]         store_data_in,
  input  logic [4:0]          write_reg_in,
  input  logic                reg_write_in,
  input  logic                mem_to_reg_in,
  mem_access_unit_if.master   dmem,
  output logic                stall,
  output logic                wb_le,
  output logic [31:0]         mem_data_out,
  output logic [31:0]         alu_data_out,
  output logic [4:0]          write_reg_out,
  output logic                reg_write_out,
  output logic                mem_to_reg_out,
  output logic                misalign_out
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t      r_state, w_state_next;
  logic        w_stall, w_issue, w_done;
  logic        w_mem_op, w_misalign;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;

  // Bus registers
  logic        r_req, r_we;
  logic [31:0] r_addr, r_wdata;
  logic [3:0]  r_be;

  // Instruction captured at issue; upstream copy is ignored while BUSY
  logic        r_is_load, r_unsigned, r_reg_write, r_mem_to_reg;
  logic [1:0]  r_size, r_lane;
  logic [31:0] r_alu;
  logic [4:0]  r_write_reg;

  // MEM/WB-facing result registers
  logic        r_wb_le, r_misalign, r_reg_write_out, r_mem_to_reg_out;
  logic [31:0] r_mem_data, r_alu_data;
  logic [4:0]  r_write_reg_out;

  assign w_mem_op   = valid_in & (mem_read_in | mem_write_in);
  assign w_misalign = ((size_in == 2'b01) & alu_result_in[0]) |
                      (size_in[1] & (|alu_result_in[1:0]));

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = store_data_in;
    case (size_in)
      2'b00: begin
        w_be    = 4'b0001 << alu_result_in[1:0];
        w_wdata = {4{store_data_in[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << alu_result_in[1:0];
        w_wdata = {2{store_data_in[15:0]}};
      end
      default: ;
    endcase
  end

  assign w_byte = dmem.dmem_rdata[{r_lane, 3'b000} +: 8];
  assign w_half = dmem.dmem_rdata[{r_lane[1], 4'b0000} +: 16];

  always_comb begin
    w_load_data = dmem.dmem_rdata;
    case (r_size)
      2'b00:   w_load_data = {{24{~r_unsigned & w_byte[7]}}, w_byte};
      2'b01:   w_load_data = {{16{~r_unsigned & w_half[15]}}, w_half};
      default: ;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_stall      = 1'b0;
    w_issue      = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_mem_op && !w_misalign) begin
          w_issue      = 1'b1;
          w_stall      = 1'b1;
          w_state_next = S_BUSY;
        end
      end
      S_BUSY: begin
        w_stall = ~dmem.dmem_ack;
        if (dmem.dmem_ack) begin
          w_done       = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req            <= 1'b0;
      r_we             <= 1'b0;
      r_addr           <= '0;
      r_be             <= '0;
      r_wdata          <= '0;
      r_is_load        <= 1'b0;
      r_unsigned       <= 1'b0;
      r_reg_write      <= 1'b0;
      r_mem_to_reg     <= 1'b0;
      r_size           <= '0;
      r_lane           <= '0;
      r_alu            <= '0;
      r_write_reg      <= '0;
      r_wb_le          <= 1'b0;
      r_misalign       <= 1'b0;
      r_reg_write_out  <= 1'b0;
      r_mem_to_reg_out <= 1'b0;
      r_mem_data       <= '0;
      r_alu_data       <= '0;
      r_write_reg_out  <= '0;
    end else begin
      r_wb_le    <= 1'b0;
      r_misalign <= 1'b0;
      if (w_issue) begin
        r_req        <= 1'b1;
        r_we         <= mem_write_in;
        r_addr       <= {alu_result_in[31:2], 2'b00};
        r_be         <= w_be;
        r_wdata      <= w_wdata;
        r_is_load    <= ~mem_write_in;
        r_unsigned   <= unsigned_in;
        r_size       <= size_in;
        r_lane       <= alu_result_in[1:0];
        r_alu        <= alu_result_in;
        r_write_reg  <= write_reg_in;
        r_reg_write  <= reg_write_in;
        r_mem_to_reg <= mem_to_reg_in;
      end else if (r_state == S_IDLE && valid_in) begin
        // Non-memory or misaligned op: retire in one cycle without touching the bus
        r_wb_le          <= 1'b1;
        r_misalign       <= w_mem_op & w_misalign;
        r_mem_data       <= '0;
        r_alu_data       <= alu_result_in;
        r_write_reg_out  <= write_reg_in;
        r_reg_write_out  <= reg_write_in & ~(w_mem_op & w_misalign);
        r_mem_to_reg_out <= mem_to_reg_in;
      end else if (w_done) begin
        r_req            <= 1'b0;
        r_wb_le          <= 1'b1;
        r_mem_data       <= r_is_load ? w_load_data : 32'h0;
        r_alu_data       <= r_alu;
        r_write_reg_out  <= r_write_reg;
        r_reg_write_out  <= r_reg_write;
        r_mem_to_reg_out <= r_mem_to_reg;
      end
    end
  end

  assign dmem.dmem_req   = r_req;
  assign dmem.dmem_we    = r_we;
  assign dmem.dmem_addr  = r_addr;
  assign dmem.dmem_be    = r_be;
  assign dmem.dmem_wdata = r_wdata;

  assign stall          = w_stall;
  assign wb_le          = r_wb_le;
  assign misalign_out   = r_misalign;
  assign mem_data_out   = r_mem_data;
  assign alu_data_out   = r_alu_data;
  assign write_reg_out  = r_write_reg_out;
  assign reg_write_out  = r_reg_write_out;
  assign mem_to_reg_out = r_mem_to_reg_out;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage data-memory access unit of the MIPS pipeline, sitting between the EX/MEM pipeline register and the MEM/WB latch. It performs loads and stores over a req/ack data-memory handshake, with byte-enable generation and load-lane extraction with sign/zero extension. It stalls upstream while an access is outstanding and presents registered results plus a one-cycle load-enable to MEM/WB.

## Interface
Parameters:
- none (fixed 32-bit datapath, 5-bit register index)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- valid_in  in  1  an instruction is present from EX/MEM
- mem_read_in  in  1  load
- mem_write_in  in  1  store; wins if both are set
- size_in  in  2  00 byte, 01 halfword, 10/11 word
- unsigned_in  in  1  zero-extend loads (lbu/lhu)
- alu_result_in  in  32  effective address / ALU passthrough
- store_data_in  in  32  store data, right-justified
- write_reg_in  in  5  destination register
- reg_write_in  in  1  register-write control
- mem_to_reg_in  in  1  writeback mux select
- dmem_req  out  1  memory request, registered
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word address, {alu[31:2],2'b00}
- dmem_be  out  4  byte enables, bit i = byte lane i (little-endian)
- dmem_wdata  out  32  lane-replicated store data
- dmem_rdata  in  32  read data, valid in the cycle dmem_ack=1
- dmem_ack  in  1  access complete
- stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM this cycle
- wb_le  out  1  load enable to MEM/WB, one-cycle pulse
- mem_data_out  out  32  extended load data
- alu_data_out  out  32  registered alu_result_in
- write_reg_out  out  5
- reg_write_out  out  1
- mem_to_reg_out  out  1
- misalign_out  out  1  misaligned-access flag, pulses with wb_le

## Operation
- FSM: IDLE, BUSY.
- IDLE, valid_in=0: wb_le=0 next cycle; result outputs hold.
- IDLE, valid_in=1, no mem op: stall=0; at the edge, register passthroughs; mem_data_out=0; wb_le=1 next cycle.
- IDLE, valid_in=1, aligned mem op: stall=1 combinationally. At the edge, capture all inputs, drive dmem_req=1 with addr/we/be/wdata, and go to BUSY.
- Misaligned: halfword with addr[0]=1, or word with addr[1:0]≠0. No request, stall=0. Next cycle: wb_le=1, misalign_out=1, reg_write_out=0, other outputs registered normally.
- BUSY: dmem_req, addr, we, be, wdata held stable; stall = !dmem_ack; inputs ignored. On the dmem_ack=1 edge: dmem_req←0, state←IDLE, outputs registered, wb_le=1 next cycle.
- Byte enables:
  - byte: 4'b0001<<addr[1:0], wdata={4{sd[7:0]}}
  - half: 4'b0011<<addr[1:0], wdata={2{sd[15:0]}}
  - word: 4'b1111, wdata=sd
- Load extract: byte lane addr[1:0], half lane addr[1]; sign-extend unless unsigned_in. Word loads pass unchanged.
- Stores: mem_data_out=0; reg_write/mem_to_reg pass through unchanged.
- dmem_ack in IDLE is ignored.

## Timing
- Reset (async, immediate): state IDLE; dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata=0; wb_le, misalign_out=0; all result outputs=0. An in-flight access is abandoned, and a later stray ack is ignored.
- Non-memory and misaligned ops: 1-cycle latency, no stall.
- Memory op accepted in cycle T: dmem_req high from T+1; ack earliest in T+1; wb_le in cycle (ack cycle)+1. stall is high from T through the cycle before ack. Minimum total latency: 2 cycles, with 1 stall cycle.
- Upstream holds the same instruction during the stall; the held copy is discarded because BUSY ignores inputs. Upstream advances on the ack edge, so back-to-back accesses are issued with no idle cycle.
- wb_le is never high for more than one cycle per instruction.

## Test plan
- ALU op, alu_result_in=0x1234_5678, write_reg_in=9, reg_write_in=1 -> next cycle wb_le=1, alu_data_out=0x12345678, write_reg_out=9, stall never 1.
- lb at addr 0x103, ack after 3 cycles with rdata=0x80FF_FF7F -> dmem_be=4'b1000, dmem_addr=0x100, stall high 3 cycles, mem_data_out=0xFFFF_FF80. Repeat as lbu -> 0x0000_0080.
- sh at addr 0x202, store_data_in=0xDEAD_BEEF, immediate ack -> dmem_we=1, be=4'b1100, wdata=0xBEEF_BEEF, wb_le 2 cycles after accept.
- lw at addr 0x6 -> no dmem_req, misalign_out=1 with wb_le, reg_write_out=0.
- rst asserted mid-BUSY, then ack arrives -> dmem_req drops immediately, all outputs 0, the ack produces no wb_le.
- Two consecutive lw (addr 0x10, 0x14), each acked in 1 cycle -> second dmem_req rises the cycle after the first ack edge; two distinct wb_le pulses with correct data.
